// File: rtl/if_stage_vec_irq.sv
// Instruction-fetch stage with vectored, prioritised, nestable interrupts and a return stack.
// Optional feature macro: IRQ_MASK_EN adds the irq_mask input that blocks individual request lines.
`timescale 1ns/1ps
module if_stage_vec_irq #(
  parameter int unsigned NUM_IRQ      = 8,
  parameter int unsigned STACK_DEPTH  = 8,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter logic [31:0] VEC_BASE     = 32'h80,
  parameter logic [31:0] VEC_STRIDE   = 32'h80,
  parameter logic [31:0] NOP_INSTR    = 32'h5400_0000,
  localparam int unsigned IDW         = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pc_src,
  input  logic [31:0]        branch_target,
  input  logic               if_flush,
  input  logic               hold_pc,
  input  logic               hold_if_id,
  input  logic [NUM_IRQ-1:0] irq_req,
`ifdef IRQ_MASK_EN
  input  logic [NUM_IRQ-1:0] irq_mask,
`endif
  input  logic               irq_ret,
  input  logic [31:0]        mem_rdata,
  input  logic               mem_ready,
  output logic               mem_start,
  output logic [31:0]        mem_addr,
  output logic [31:0]        id_pc,
  output logic [31:0]        id_instr,
  output logic               irq_active,
  output logic [IDW-1:0]     irq_level,
  output logic               stack_ovf
);

  localparam int unsigned AW  = $clog2(STACK_DEPTH);
  localparam int unsigned SPW = AW + 1;
  localparam int unsigned CW  = $clog2(DRAIN_CYCLES) + 1;

  typedef enum logic {FetchReq, FetchWait} fetch_e;
  typedef enum logic [1:0] {IrqIdle, IrqDrain, IrqVector} irq_e;

  fetch_e             fetch_q, fetch_d;
  irq_e               irq_st_q, irq_st_d;
  logic [31:0]        pc_q, pc_d, seq_pc, vec_pc;
  logic               mem_start_q;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IDW-1:0]     pend_id_q, pend_id_d;
  logic               ovf_q, ovf_d;
  logic [SPW-1:0]     sp_q;
  logic [31:0]        ret_pc_q [STACK_DEPTH];
  logic [IDW-1:0]     ret_id_q [STACK_DEPTH];
  logic [IDW-1:0]     level_q;
  logic               active_q;
  logic [NUM_IRQ-1:0] req_m;
  logic               irq_found;
  logic [IDW-1:0]     irq_sel;
  logic               adv, pop, push, stack_empty, stack_full;
  logic [AW-1:0]      top_idx, under_idx, push_idx;

`ifdef IRQ_MASK_EN
  assign req_m = irq_req & ~irq_mask;
`else
  assign req_m = irq_req;
`endif

  assign adv         = mem_ready && !hold_pc;
  assign stack_empty = (sp_q == '0);
  assign stack_full  = (sp_q == SPW'(STACK_DEPTH));
  assign pop         = adv && irq_ret && !stack_empty;
  // A return pops ahead of a pending vector; the vector retries on the next advance edge.
  assign push        = adv && !pop && (irq_st_q == IrqVector);
  assign top_idx     = AW'(sp_q - SPW'(1));
  assign under_idx   = AW'(sp_q - SPW'(2));
  assign push_idx    = sp_q[AW-1:0];
  assign vec_pc      = VEC_BASE + VEC_STRIDE * 32'(pend_id_q);

  // Lowest eligible index wins; nesting only admits indices below the active level.
  always_comb begin
    irq_found = 1'b0;
    irq_sel   = '0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (req_m[i] && (stack_empty || (i < int'(level_q)))) begin
        irq_found = 1'b1;
        irq_sel   = IDW'(i);
      end
    end
  end

  always_comb begin
    seq_pc = pc_src ? branch_target : pc_q + 32'd4;
    if (pop) begin
      pc_d = ret_pc_q[top_idx];
    end else if (push) begin
      pc_d = vec_pc;
    end else begin
      pc_d = seq_pc;
    end
  end

  always_comb begin
    fetch_d = fetch_q;
    unique case (fetch_q)
      FetchReq:  fetch_d = FetchWait;
      FetchWait: if (mem_ready) fetch_d = FetchReq;
    endcase
  end

  always_comb begin
    irq_st_d  = irq_st_q;
    cnt_d     = cnt_q;
    pend_id_d = pend_id_q;
    ovf_d     = ovf_q;
    case (irq_st_q)
      IrqIdle: begin
        if (irq_found) begin
          if (stack_full) begin
            ovf_d = 1'b1;
          end else begin
            irq_st_d  = IrqDrain;
            pend_id_d = irq_sel;
            cnt_d     = CW'(DRAIN_CYCLES - 1);
          end
        end
      end
      IrqDrain: begin
        if (cnt_q == '0) irq_st_d = IrqVector;
        else             cnt_d    = cnt_q - CW'(1);
      end
      IrqVector: if (push) irq_st_d = IrqIdle;
      default:   irq_st_d = IrqIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      fetch_q     <= FetchReq;
      mem_start_q <= 1'b0;
      irq_st_q    <= IrqIdle;
      cnt_q       <= '0;
      pend_id_q   <= '0;
      ovf_q       <= 1'b0;
      id_pc       <= '0;
      id_instr    <= NOP_INSTR;
    end else begin
      fetch_q     <= fetch_d;
      mem_start_q <= (fetch_q == FetchReq);
      irq_st_q    <= irq_st_d;
      cnt_q       <= cnt_d;
      pend_id_q   <= pend_id_d;
      ovf_q       <= ovf_d;
      if (adv) pc_q <= pc_d;
      if (mem_ready && !hold_if_id) begin
        id_pc    <= pc_q + 32'd4;
        id_instr <= (if_flush || mem_rdata == '0) ? NOP_INSTR : mem_rdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q     <= '0;
      level_q  <= '0;
      active_q <= 1'b0;
      for (int i = 0; i < int'(STACK_DEPTH); i++) begin
        ret_pc_q[i] <= '0;
        ret_id_q[i] <= '0;
      end
    end else if (push) begin
      ret_pc_q[push_idx] <= seq_pc;
      ret_id_q[push_idx] <= pend_id_q;
      sp_q               <= sp_q + SPW'(1);
      level_q            <= pend_id_q;
      active_q           <= 1'b1;
    end else if (pop) begin
      sp_q <= sp_q - SPW'(1);
      if (sp_q == SPW'(1)) begin
        level_q  <= '0;
        active_q <= 1'b0;
      end else begin
        level_q <= ret_id_q[under_idx];
      end
    end
  end

  assign mem_start  = mem_start_q;
  assign mem_addr   = pc_q;
  assign irq_active = active_q;
  assign irq_level  = level_q;
  assign stack_ovf  = ovf_q;

endmodule
